// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch and load/store
// data accesses. In IDLE the arbiter grants one pending requester, registers
// its access onto the memory port and moves to BUSY. In BUSY it waits for
// mem_ack, or aborts through the watchdog, then returns to IDLE. The owner of
// the finished access receives a one-cycle done pulse. The pipeline stall
// fed to control_unit is also driven here.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_done) and address
//   if_done/if_rdata      fetch completion pulse and instruction word
//   d_rd/d_wr             load / store request (held until d_done); both = store
//   d_addr/d_wdata/d_be   data address, store data, store byte enables
//   d_done/d_rdata        data completion pulse and load data
//   mem_req/mem_we        memory request (held until ack/abort), write strobe
//   mem_addr/mem_wdata    registered memory address and write data
//   mem_be                registered byte enables (all ones for reads)
//   mem_ack/mem_rdata     memory completion pulse and read data
//   stall                 pipeline stall while any request is unfinished
//   err                   one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall,
  output logic                    err
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WDOG_EN   = (TIMEOUT != 0);
  // Counter value on the last busy cycle before the watchdog fires.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic { ST_IDLE, ST_BUSY } state_t;
  typedef enum logic { OWN_FETCH, OWN_DATA } owner_t;

  state_t                 state;
  // owner keeps its value while IDLE, so it also serves as the last owner
  // for round-robin arbitration.
  owner_t                 owner;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   data_pend;
  logic                   fetch_pend;
  logic                   grant_data;
  logic                   busy;
  logic                   ack_hit;
  logic                   abort;
  logic                   fin;
  logic [DATA_WIDTH-1:0]  rd_data;

  assign data_pend  = d_rd | d_wr;
  assign fetch_pend = if_req;

  // Data wins when it is alone, or when both pend and fetch went last.
  assign grant_data = data_pend & (~fetch_pend | (owner == OWN_FETCH));

  assign busy    = (state == ST_BUSY);
  assign ack_hit = busy & mem_ack;
  // A real ack in the final cycle beats the watchdog.
  assign abort   = busy & ~mem_ack & WDOG_EN & (cnt == CNT_LAST);
  assign fin     = ack_hit | abort;

  assign mem_req = busy;
  assign err     = abort;

  assign if_done = fin & (owner == OWN_FETCH);
  assign d_done  = fin & (owner == OWN_DATA);

  // Read data passes only on an acknowledged read; writes and aborts give 0.
  assign rd_data  = (ack_hit & ~mem_we) ? mem_rdata : '0;
  assign if_rdata = if_done ? rd_data : '0;
  assign d_rdata  = d_done  ? rd_data : '0;

  // Gated by rst_n so the stall is low throughout reset.
  assign stall = rst_n & (data_pend | fetch_pend) & ~(if_done | d_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_FETCH;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_pend | fetch_pend) begin
            state <= ST_BUSY;
            cnt   <= '0;
            if (grant_data) begin
              owner     <= OWN_DATA;
              mem_we    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wr ? d_wdata : '0;
              mem_be    <= d_wr ? d_be : {BE_WIDTH{1'b1}};
            end else begin
              owner     <= OWN_FETCH;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= {BE_WIDTH{1'b1}};
            end
          end
        end
        ST_BUSY: begin
          if (fin) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
